// File: rtl/fir_inverse_filter.sv
// Receive-side deconvolver undoing the 4-tap forward FIR with one shared multiplier.
// Optional sticky saturation flag (ports clr_ovf/ovf) enabled by defining OVF_STICKY_EN.
module fir_inverse_filter #(
  parameter logic signed [7:0] H1       = 8'sd2,
  parameter logic signed [7:0] H2       = 8'sd3,
  parameter logic signed [7:0] H3       = 8'sd4,
  parameter int unsigned       H0_SHIFT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  x_out,
  output logic        out_valid,
  input  logic        out_ready
`ifdef OVF_STICKY_EN
  ,
  input  logic        clr_ovf,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2,
    OUT  = 2'd3
  } state_e;

  state_e             state_q;
  logic signed [19:0] acc_q;
  logic        [1:0]  tap_q;
  logic signed [7:0]  xh1_q;
  logic signed [7:0]  xh2_q;
  logic signed [7:0]  xh3_q;
  logic        [7:0]  x_out_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic signed [7:0]  coef_s;
  logic signed [7:0]  hist_s;
  logic signed [15:0] prod_s;
  logic signed [19:0] prod_ext_s;
  logic signed [19:0] shift_s;
  logic signed [7:0]  sat_s;
  logic               sat_hit_s;

  // Tap select feeding the single time-shared multiplier
  always_comb begin
    coef_s = 8'sd0;
    hist_s = 8'sd0;
    case (tap_q)
      2'd1: begin
        coef_s = H1;
        hist_s = xh1_q;
      end
      2'd2: begin
        coef_s = H2;
        hist_s = xh2_q;
      end
      2'd3: begin
        coef_s = H3;
        hist_s = xh3_q;
      end
      default: begin
        coef_s = 8'sd0;
        hist_s = 8'sd0;
      end
    endcase
  end

  assign prod_s     = coef_s * hist_s;
  assign prod_ext_s = {{4{prod_s[15]}}, prod_s};
  assign shift_s    = acc_q >>> H0_SHIFT;

  // Clip the scaled accumulator into the 8-bit output range
  always_comb begin
    sat_s     = shift_s[7:0];
    sat_hit_s = 1'b0;
    if (shift_s > 20'sd127) begin
      sat_s     = 8'sd127;
      sat_hit_s = 1'b1;
    end else if (shift_s < -20'sd128) begin
      sat_s     = -8'sd128;
      sat_hit_s = 1'b1;
    end else begin
      sat_s     = shift_s[7:0];
      sat_hit_s = 1'b0;
    end
  end

  // Control FSM together with datapath and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= 20'sd0;
      tap_q       <= 2'd0;
      xh1_q       <= 8'sd0;
      xh2_q       <= 8'sd0;
      xh3_q       <= 8'sd0;
      x_out_q     <= 8'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q      <= {{4{y_in[15]}}, y_in};
            tap_q      <= 2'd1;
            in_ready_q <= 1'b0;
            state_q    <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q - prod_ext_s;
          if (tap_q == 2'd3) begin
            tap_q   <= 2'd0;
            state_q <= DONE;
          end else begin
            tap_q <= tap_q + 2'd1;
          end
        end
        DONE: begin
          // The clipped value, not the raw one, becomes the new history
          x_out_q     <= sat_s;
          out_valid_q <= 1'b1;
          xh1_q       <= sat_s;
          xh2_q       <= xh1_q;
          xh3_q       <= xh2_q;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          tap_q       <= 2'd0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign x_out     = x_out_q;
  assign out_valid = out_valid_q;

`ifdef OVF_STICKY_EN
  logic ovf_q;

  // Sticky flag: a saturation in DONE takes priority over a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if ((state_q == DONE) && sat_hit_s) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fir_inverse_filter.sv
// Self-checking bench for fir_inverse_filter: vector table, scoreboard queue,
// and hand-written sequences for backpressure, mid-operation reset and the ovf flag.
module tb_fir_inverse_filter;

  localparam int LATENCY = 4;  // edges from the accepting edge to out_valid high

  logic        clk;
  logic        reset;
  logic [15:0] y_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x_out;
  logic        out_valid;
  logic        out_ready;
`ifdef OVF_STICKY_EN
  logic        clr_ovf;
  logic        ovf;
`endif

  int n_checks;
  int n_fail;
  int exp_q[$];
  int mh1, mh2, mh3;

  typedef struct {
    logic        rst;
    logic [15:0] y;
    int          x;
  } vec_t;

  vec_t vecs[9];

  fir_inverse_filter dut (
    .clk      (clk),
    .reset    (reset),
    .y_in     (y_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_out    (x_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef OVF_STICKY_EN
    ,
    .clr_ovf  (clr_ovf),
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Independent reference of the recursion with default coefficients
  function automatic int model_step(input int y);
    int r;
    r = y - 2 * mh1 - 3 * mh2 - 4 * mh3;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    mh3 = mh2;
    mh2 = mh1;
    mh1 = r;
    return r;
  endfunction

  // Scoreboard: compare at the edge where the output handshake will occur
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d, expected no output", int'(signed'(x_out)));
      end else begin
        chk("x_out", int'(signed'(x_out)), exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y_in      = 16'd0;
    exp_q.delete();
    mh1 = 0;
    mh2 = 0;
    mh3 = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [15:0] y, input int exp, input bit chk_lat, input bit wait_done);
    int waited;
    int lat;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0, expected 1 within 100 cycles");
      return;
    end
    in_valid = 1'b1;
    y_in     = y;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    if (chk_lat) chk("latency", lat, LATENCY);
    if (wait_done) begin
      waited = 0;
      while (out_valid && waited < 100) begin
        @(posedge clk);
        #1;
        waited++;
      end
      chk("handshake_done", int'(out_valid), 0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y_in      = 16'd0;
`ifdef OVF_STICKY_EN
    clr_ovf   = 1'b0;
`endif
    vecs[0] = '{1'b1, 16'd1,   1};
    vecs[1] = '{1'b0, 16'd2,   0};
    vecs[2] = '{1'b0, 16'd3,   0};
    vecs[3] = '{1'b0, 16'd4,   0};
    vecs[4] = '{1'b1, 16'd5,   5};
    vecs[5] = '{1'b0, 16'd7,   -3};
    vecs[6] = '{1'b0, 16'd0,   -9};
    vecs[7] = '{1'b1, 16'd200, 127};
    vecs[8] = '{1'b0, 16'd0,   -128};

    #3;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_x_out", int'(x_out), 0);
    do_reset();
    chk("reset_in_ready", int'(in_ready), 1);

    // Impulse, mixed signs and saturation vectors
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset();
      send(vecs[i].y, vecs[i].x, 1'b1, 1'b1);
    end

    // Backpressure: output held, second request ignored
    do_reset();
    out_ready = 1'b0;
    send(16'd5, 5, 1'b1, 1'b0);
    in_valid = 1'b1;
    y_in     = 16'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_x_out", int'(signed'(x_out)), 5);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_released", int'(out_valid), 0);
    send(16'd9, -1, 1'b1, 1'b1);

    // Reset while the MAC is on tap 2
    do_reset();
    in_valid = 1'b1;
    y_in     = 16'd50;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_output", int'(out_valid), 0);
    send(16'd1, 1, 1'b0, 1'b1);
    send(16'd2, 0, 1'b0, 1'b1);

    // Random stream against the reference model
    do_reset();
    for (int i = 0; i < 20; i++) begin
      int y;
      y = int'($urandom_range(4000)) - 2000;
      send(16'(y), model_step(y), 1'b0, 1'b1);
    end

`ifdef OVF_STICKY_EN
    do_reset();
    chk("ovf_reset", int'(ovf), 0);
    send(16'd200, 127, 1'b0, 1'b1);
    chk("ovf_set", int'(ovf), 1);
    send(16'd300, 46, 1'b0, 1'b1);
    chk("ovf_sticky", int'(ovf), 1);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);
    clr_ovf = 1'b1;
    send(16'd0, -128, 1'b0, 1'b0);
    chk("ovf_sat_wins", int'(ovf), 1);
    clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("ovf_after_wins", int'(ovf), 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
